// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, access-size codes and MEM-stage FSM encoding
package riscv_pkg;

    localparam int XLEN = 32;

    // funct3[1:0] access size; funct3[2] selects zero-extension on loads
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores, extension for loads, alignment check
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned
);

    logic [XLEN-1:0] shifted;
    logic            sext;

    always_comb begin
        shifted    = rdata >> {addr_lo, 3'b000};
        sext       = ~funct3[2];
        wstrb      = 4'b1111;
        wdata      = store_data;
        load_data  = shifted;
        misaligned = 1'b0;
        case (funct3[1:0])
            SZ_B: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_data  = {{16{sext & shifted[15]}}, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: drives the req/gnt/rvalid data bus, stalls, registers MEM/WB
module mem_access_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_RegWrite,
    input  logic            mem_MemtoReg,
    input  logic            mem_MemRead,
    input  logic            mem_MemWrite,
    input  logic [4:0]      mem_rd,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_write_data,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [XLEN-1:0] dbus_wdata,
    output logic [3:0]      dbus_wstrb,
    input  logic            dbus_gnt,
    input  logic            dbus_rvalid,
    input  logic [XLEN-1:0] dbus_rdata,
    input  logic            dbus_err,
    output logic            mem_stall,
    output logic            wb_RegWrite,
    output logic            wb_MemtoReg,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_load_data,
    output logic            exc_misaligned,
    output logic            exc_bus_err,
    output logic [XLEN-1:0] exc_addr
);

    mem_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [3:0]      wstrb_q;
    logic            we_q;
    logic [2:0]      funct3_q;

    logic            access, in_idle, timeout_hit;
    logic [1:0]      al_addr;
    logic [2:0]      al_f3;
    logic [3:0]      al_wstrb;
    logic [XLEN-1:0] al_wdata, al_load;
    logic            al_mis;
    logic            stall_c, req_c, start;
    logic            cap_pass, cap_mis, cap_done, cap_to;

    assign access      = mem_MemRead | mem_MemWrite;
    assign in_idle     = (state == IDLE);
    // The aligner sees live inputs while idle and the latched access afterwards
    assign al_addr     = in_idle ? mem_alu_result[1:0] : addr_q[1:0];
    assign al_f3       = in_idle ? mem_funct3 : funct3_q;
    assign timeout_hit = !in_idle && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    lsu_align u_align (
        .addr_lo    (al_addr),
        .funct3     (al_f3),
        .store_data (mem_write_data),
        .rdata      (dbus_rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_mis)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        req_c     = 1'b0;
        start     = 1'b0;
        cap_pass  = 1'b0;
        cap_mis   = 1'b0;
        cap_done  = 1'b0;
        cap_to    = 1'b0;
        case (state)
            IDLE: begin
                if (!access)     cap_pass = 1'b1;
                else if (al_mis) cap_mis  = 1'b1;
                else begin
                    start     = 1'b1;
                    stall_c   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (timeout_hit) begin
                    cap_to    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    if (dbus_gnt) state_nxt = RESP;
                end
            end
            RESP: begin
                if (dbus_rvalid) begin
                    cap_done  = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    cap_to    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
        end else if (start) begin
            cnt      <= '0;
            addr_q   <= mem_alu_result;
            wdata_q  <= al_wdata;
            wstrb_q  <= mem_MemWrite ? al_wstrb : 4'b0000;
            we_q     <= mem_MemWrite;
            funct3_q <= mem_funct3;
        end else if (!in_idle) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Edges without a capture leave a bubble: no write-back, no exception
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_RegWrite    <= 1'b0;
            wb_MemtoReg    <= 1'b0;
            wb_rd          <= '0;
            wb_alu_result  <= '0;
            wb_load_data   <= '0;
            exc_misaligned <= 1'b0;
            exc_bus_err    <= 1'b0;
            exc_addr       <= '0;
        end else begin
            wb_RegWrite    <= 1'b0;
            wb_MemtoReg    <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_bus_err    <= 1'b0;
            if (cap_pass | cap_mis | cap_done | cap_to) begin
                wb_rd         <= mem_rd;
                wb_alu_result <= mem_alu_result;
            end
            if (cap_pass) begin
                wb_RegWrite  <= mem_RegWrite;
                wb_MemtoReg  <= mem_MemtoReg;
                wb_load_data <= '0;
            end
            if (cap_mis) begin
                exc_misaligned <= 1'b1;
                exc_addr       <= mem_alu_result;
            end
            if (cap_done) begin
                wb_RegWrite  <= mem_RegWrite & ~dbus_err;
                wb_MemtoReg  <= mem_MemtoReg;
                wb_load_data <= we_q ? '0 : al_load;
                exc_bus_err  <= dbus_err;
                if (dbus_err) exc_addr <= addr_q;
            end
            if (cap_to) begin
                exc_bus_err <= 1'b1;
                exc_addr    <= addr_q;
            end
        end
    end

    assign dbus_req   = req_c;
    assign dbus_we    = we_q;
    assign dbus_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign dbus_wdata = wdata_q;
    assign dbus_wstrb = wstrb_q;
    assign mem_stall  = reset & stall_c;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory (MEM) stage; sits directly downstream of the EX/MEM pipeline register.
- Turns the latched load/store control, address (ALU result) and store data into a request/grant/response data-bus transaction.
- Aligns, byte-enables and sign/zero-extends data; stalls the pipeline while the bus is busy.
- Registers results into the MEM/WB boundary. Detects misalignment and bus errors/timeouts.

Parameters:
TIMEOUT_CYCLES, 64, cycles spent in REQ+RESP before an access is aborted as a bus error (min 2)
CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
mem_RegWrite, mem_MemtoReg, mem_MemRead, mem_MemWrite  in  1 each  control from EX/MEM register
mem_rd  in  5  destination register
mem_funct3  in  3  access size/sign: [1:0] 00=byte, 01=half, 1x=word; [2]=1 zero-extend
mem_alu_result  in  32  byte address, or result for non-memory ops
mem_write_data  in  32  store data (rs2 value)
dbus_req  out  1  request valid
dbus_we  out  1  1=write
dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dbus_wdata  out  32  lane-replicated store data
dbus_wstrb  out  4  byte enables (0000 on reads)
dbus_gnt  in  1  request accepted this cycle
dbus_rvalid  in  1  response (read data or write ack) valid
dbus_rdata  in  32  read data
dbus_err  in  1  error qualifier, sampled with dbus_rvalid
mem_stall  out  1  hold IF..EX/MEM this cycle
wb_RegWrite, wb_MemtoReg  out  1 each  to writeback
wb_rd  out  5  destination
wb_alu_result  out  32  passthrough
wb_load_data  out  32  extended load value
exc_misaligned, exc_bus_err  out  1 each  one-cycle exception pulses, aligned with the wb_* entry
exc_addr  out  32  faulting byte address

Behaviour:
- Reset: state IDLE; counter 0; all outputs 0, including dbus_req and all wb_*/exc_*.
- Reset mid-transaction abandons the access immediately; the bus side must tolerate this.
- access = MemRead|MemWrite. Both set means store.
- FSM states: IDLE, REQ, RESP.
- Aligned = byte always; half needs addr[0]=0; word needs addr[1:0]=0.
- IDLE, no access: capture passthrough into wb_* at the edge; latency 1; mem_stall=0.
- IDLE, access misaligned: no bus activity; mem_stall=0.
  - Next edge: wb_RegWrite=0, exc_misaligned=1, exc_addr=address.
- IDLE, access aligned: mem_stall=1. Latch address, we, wstrb, wdata and funct3 into internal registers. Go to REQ.
- REQ: dbus_req=1, driven from registers and stable until gnt. On gnt, go to RESP.
- RESP: dbus_req=0. On rvalid, mem_stall=0 that cycle and wb_* capture at the edge:
  - wb_load_data = extended data, or 0 for stores.
  - wb_RegWrite = mem_RegWrite & ~dbus_err.
  - exc_bus_err = dbus_err.
  - Return to IDLE.
- gnt and rvalid in the same cycle: gnt advances to RESP; that rvalid is ignored. The bus never does this.
- mem_stall = (IDLE & access & aligned) | REQ | (RESP & ~rvalid).
- Minimum aligned-access latency: 3 cycles (IDLE, REQ with gnt, RESP with rvalid).
- wb_* hold a non-memory "bubble" (RegWrite=0, exc=0) on every stalled edge.
- Timeout: counter clears on leaving IDLE and increments each REQ/RESP cycle. At TIMEOUT_CYCLES-1 without completion:
  - exc_bus_err=1 and wb_RegWrite=0.
  - dbus_req drops; return to IDLE; mem_stall=0 that cycle.
- Store formatting:
  - byte: wdata={4{d[7:0]}}, wstrb=0001<<addr[1:0].
  - half: wdata={2{d[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - word: wdata=d, wstrb=1111.
- Load: shifted = rdata >> (8*addr[1:0]); take byte/half/word; sign-extend unless funct3[2].
- exc_* are one-cycle pulses; both are never set together.

Decomposition:
- Shared package riscv_pkg:
  - funct3 size codes (SZ_B, SZ_H, SZ_W).
  - mem FSM state encoding (2-bit: IDLE, REQ, RESP).
  - XLEN=32.
- One combinational sub-module, lsu_align: addr[1:0] + funct3 + store data/read data → wstrb, wdata, extended load, misaligned flag.
- The FSM, counter and WB registers stay in the top module.

Test Plan:
1. Non-memory op, alu_result=0x0000_1234, rd=5, RegWrite=1 → next edge wb_alu_result=0x1234, wb_rd=5, wb_RegWrite=1; mem_stall never asserted.
2. LB funct3=000, addr=0x103, gnt at cycle 1, rvalid at cycle 2 with rdata=0x80FF_0000 → dbus_addr=0x100, wstrb=0000; wb_load_data=0xFFFF_FF80; mem_stall high exactly 2 cycles.
3. SH addr=0x22, data=0xDEAD_BEEF → dbus_we=1, wstrb=1100, wdata=0xBEEF_BEEF; hold gnt low 3 cycles → dbus_req and dbus_addr stable throughout.
4. LW addr=0x202 → no dbus_req; next edge exc_misaligned=1, exc_addr=0x202, wb_RegWrite=0.
5. LHU addr=0x40, gnt then never rvalid, TIMEOUT_CYCLES=8 → exc_bus_err pulse after 8 cycles in REQ+RESP, FSM back to IDLE; separately, rvalid with dbus_err=1 → exc_bus_err, wb_RegWrite=0.
6. Assert reset low while in RESP → dbus_req, mem_stall and all wb_*/exc_* go 0 immediately (asynchronously); after release, next LW at addr=0x0 completes normally.
